// File: rtl/kmeans_centroid_update.sv
// K-means centroid update: accumulates per-cluster feature sums and counts over an epoch,
// then divides each sum by its count with one shared restoring divider.
module kmeans_centroid_update #(
  parameter int DW       = 8,
  parameter int CLUSTERS = 2,
  parameter int PARAMS   = 13,
  parameter int CNT_W    = 16,
  localparam int CW      = (CLUSTERS > 1) ? $clog2(CLUSTERS) : 1,
  localparam int SW      = DW + CNT_W
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         enable_i,
  input  logic                         load_i,
  input  logic [CLUSTERS*PARAMS*DW-1:0] centroid_init_i,
  input  logic [PARAMS*DW-1:0]         data_i,
  input  logic [CW-1:0]                cluster_i,
  input  logic                         sample_valid_i,
  output logic                         sample_ready_o,
  input  logic                         epoch_done_i,
  output logic [CLUSTERS*PARAMS*DW-1:0] centroid_o,
  output logic                         centroid_valid_o,
  output logic [31:0]                  status_o
);

  // state | meaning
  // IDLE  | waiting for load_i / enable_i
  // ACCUM | accepting samples into sums/counts
  // DIV   | dividing every element, results into shadow
  // DONE  | shadow copied to centroid_o, one-cycle valid pulse
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ACCUM = 4'b0010,
    DIV   = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  localparam int NE = CLUSTERS * PARAMS;
  localparam int EW = (NE > 1) ? $clog2(NE) : 1;
  localparam int PW = (PARAMS > 1) ? $clog2(PARAMS) : 1;
  localparam int BW = $clog2(SW + 1);
  localparam logic [EW-1:0]    E_LAST  = EW'(NE - 1);
  localparam logic [PW-1:0]    P_LAST  = PW'(PARAMS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;

  logic [SW-1:0]    sums   [NE];
  logic [CNT_W-1:0] counts [CLUSTERS];
  logic [DW-1:0]    shadow [NE];
  logic [CLUSTERS*PARAMS*DW-1:0] centroid_q;
  logic ovf, bad;

  logic [CNT_W-1:0] rem, dvs, rem_nxt, cnt_sel;
  logic [SW-1:0]    quo, quo_nxt;
  logic [CNT_W:0]   rem_sh, diff;
  logic             q_bit, load_phase, last_shift, div_done, bad_in;
  logic [BW-1:0]    bit_cnt;
  logic [EW-1:0]    e_idx;
  logic [PW-1:0]    p_idx;
  logic [CW-1:0]    c_idx;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh  = {rem, quo[SW-1]};
    diff    = rem_sh - {1'b0, dvs};
    q_bit   = ~diff[CNT_W];
    rem_nxt = q_bit ? diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
    quo_nxt = {quo[SW-2:0], q_bit};
  end

  always_comb begin
    cnt_sel = '0;
    for (int c = 0; c < CLUSTERS; c++)
      if (cluster_i == CW'(c)) cnt_sel = counts[c];
  end

  assign bad_in     = 32'(cluster_i) >= 32'(CLUSTERS);
  assign last_shift = (state == DIV) && !load_phase && (bit_cnt == BW'(1));
  assign div_done   = last_shift && (e_idx == E_LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!load_i && enable_i) state_nxt = ACCUM;
      ACCUM:   if (epoch_done_i) state_nxt = DIV;
      DIV:     if (div_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sample_ready_o   = (state == ACCUM);
    centroid_valid_o = (state == DONE);
    status_o         = {26'd0, bad, ovf, state};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int e = 0; e < NE; e++) begin
        sums[e]   <= '0;
        shadow[e] <= '0;
      end
      for (int c = 0; c < CLUSTERS; c++) counts[c] <= '0;
      centroid_q <= '0;
      ovf        <= 1'b0;
      bad        <= 1'b0;
      rem        <= '0;
      dvs        <= '0;
      quo        <= '0;
      bit_cnt    <= '0;
      load_phase <= 1'b1;
      e_idx      <= '0;
      p_idx      <= '0;
      c_idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_i) begin
            centroid_q <= centroid_init_i;
          end else if (enable_i) begin
            // Shadow starts from the live centroids so empty clusters keep their values.
            for (int e = 0; e < NE; e++) begin
              sums[e]   <= '0;
              shadow[e] <= centroid_q[e*DW +: DW];
            end
            for (int c = 0; c < CLUSTERS; c++) counts[c] <= '0;
            ovf        <= 1'b0;
            bad        <= 1'b0;
            load_phase <= 1'b1;
            e_idx      <= '0;
            p_idx      <= '0;
            c_idx      <= '0;
          end
        end
        ACCUM: begin
          if (sample_valid_i) begin
            if (bad_in) begin
              bad <= 1'b1;
            end else if (cnt_sel == CNT_MAX) begin
              ovf <= 1'b1;
            end else begin
              for (int c = 0; c < CLUSTERS; c++) begin
                if (cluster_i == CW'(c)) begin
                  counts[c] <= counts[c] + 1'b1;
                  for (int p = 0; p < PARAMS; p++)
                    sums[c*PARAMS+p] <= sums[c*PARAMS+p] + SW'(data_i[p*DW +: DW]);
                end
              end
            end
          end
        end
        DIV: begin
          if (load_phase) begin
            rem        <= '0;
            quo        <= sums[e_idx];
            dvs        <= counts[c_idx];
            bit_cnt    <= BW'(SW);
            load_phase <= 1'b0;
          end else begin
            rem     <= rem_nxt;
            quo     <= quo_nxt;
            bit_cnt <= bit_cnt - 1'b1;
            if (last_shift) begin
              if (dvs != '0) shadow[e_idx] <= quo_nxt[DW-1:0];
              load_phase <= 1'b1;
              e_idx      <= e_idx + 1'b1;
              if (p_idx == P_LAST) begin
                p_idx <= '0;
                c_idx <= c_idx + 1'b1;
              end else begin
                p_idx <= p_idx + 1'b1;
              end
            end
          end
        end
        DONE: begin
          for (int e = 0; e < NE; e++) centroid_q[e*DW +: DW] <= shadow[e];
        end
        default: ;
      endcase
    end
  end

  assign centroid_o = centroid_q;

endmodule
